// File: rtl/id_ex_pipe_if.sv
// Decode-to-execute bus: upstream handshake and payload plus the registered execute-side view.
// master = decoder/ALU environment, slave = the pipeline stage.
interface id_ex_pipe_if #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [RAW-1:0]  rd_addr;
    logic            rd_wen;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] op1_dly;
    logic [XLEN-1:0] op2_dly;
    logic [RAW-1:0]  rd_addr_dly;
    logic            rd_wen_dly;

    modport master (
        output in_valid, op1, op2, rd_addr, rd_wen, out_ready,
        input  in_ready, out_valid, op1_dly, op2_dly, rd_addr_dly, rd_wen_dly
    );

    modport slave (
        input  in_valid, op1, op2, rd_addr, rd_wen, out_ready,
        output in_ready, out_valid, op1_dly, op2_dly, rd_addr_dly, rd_wen_dly
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline stage with valid/ready handshake, synchronous flush, optional
// 2-entry skid buffer and a saturating stall-cycle counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_EMPTY | no entry held, out_valid=0
//   ST_BUSY  | main entry valid on the execute side, skid empty
//   ST_FULL  | main and skid both valid, in_ready=0 (SKID=1 only)
module id_ex_pipe #(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             flush,
    id_ex_pipe_if.slave      bus,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t state;
    state_t state_nxt;

    logic main_v;
    logic skid_v;
    logic xfer_in;
    logic xfer_out;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    logic [XLEN-1:0] main_op1;
    logic [XLEN-1:0] main_op2;
    logic [RAW-1:0]  main_rd_addr;
    logic            main_rd_wen;
    logic [XLEN-1:0] skid_op1;
    logic [XLEN-1:0] skid_op2;
    logic [RAW-1:0]  skid_rd_addr;
    logic            skid_rd_wen;

    assign main_v = (state != ST_EMPTY);
    assign skid_v = (state == ST_FULL);

    // With SKID=1 in_ready depends only on the state flops, breaking the
    // combinational path from out_ready back to the decoder.
    assign bus.in_ready = (SKID != 0) ? !skid_v : (!main_v || bus.out_ready);

    assign xfer_in  = bus.in_valid && bus.in_ready && !flush;
    assign xfer_out = main_v && bus.out_ready;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        load_main_in = 1'b1;
                        state_nxt    = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (xfer_in && xfer_out) begin
                        load_main_in = 1'b1;
                    end else if (xfer_in) begin
                        // only reachable with SKID=1: SKID=0 accepts only while draining
                        load_skid = 1'b1;
                        state_nxt = ST_FULL;
                    end else if (xfer_out) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (xfer_out) begin
                        load_main_skid = 1'b1;
                        state_nxt      = ST_BUSY;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            main_op1     <= '0;
            main_op2     <= '0;
            main_rd_addr <= '0;
            main_rd_wen  <= 1'b0;
        end else if (load_main_in) begin
            main_op1     <= bus.op1;
            main_op2     <= bus.op2;
            main_rd_addr <= bus.rd_addr;
            main_rd_wen  <= bus.rd_wen;
        end else if (load_main_skid) begin
            main_op1     <= skid_op1;
            main_op2     <= skid_op2;
            main_rd_addr <= skid_rd_addr;
            main_rd_wen  <= skid_rd_wen;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            skid_op1     <= '0;
            skid_op2     <= '0;
            skid_rd_addr <= '0;
            skid_rd_wen  <= 1'b0;
        end else if (load_skid) begin
            skid_op1     <= bus.op1;
            skid_op2     <= bus.op2;
            skid_rd_addr <= bus.rd_addr;
            skid_rd_wen  <= bus.rd_wen;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stall_cnt <= '0;
        end else if (main_v && !bus.out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.out_valid   = main_v;
    assign bus.op1_dly     = main_op1;
    assign bus.op2_dly     = main_op2;
    assign bus.rd_addr_dly = main_rd_addr;
    assign bus.rd_wen_dly  = main_rd_wen && main_v;

endmodule
